// File: rtl/station_cmd_ctrl.sv
// station_cmd_ctrl: go/stop command and barcode station sequencer for a line-following robot.
// Optional obstacle buzzer is built when OBSTACLE_BUZZ_EN is defined.
module station_cmd_ctrl
`ifdef OBSTACLE_BUZZ_EN
#(
   parameter int BUZZ_HALF = 6250
)
`endif
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] cmd,
   input  logic       cmd_rdy,
   output logic       clr_cmd_rdy,
   input  logic [7:0] ID,
   input  logic       ID_vld,
   output logic       clr_ID_vld,
   input  logic       OK2Move,
   output logic       in_transit,
   output logic       go,
   output logic       buzz,
   output logic       buzz_n
);
   typedef enum logic {IDLE, TRANSIT} state_t;
   state_t state;
   logic [5:0] dest_id;
   logic cmd_q, id_q, id_match;
   // a valid is consumed only in its first high cycle, so a held valid never re-pulses
   assign clr_cmd_rdy = cmd_rdy & ~cmd_q;
   assign clr_ID_vld = ID_vld & ~id_q;
   assign id_match = clr_ID_vld && ID[7:6] == 2'b00 && ID[5:0] == dest_id;
   assign go = in_transit & OK2Move;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         in_transit <= 1'b0;
         dest_id <= '0;
         cmd_q <= 1'b0;
         id_q <= 1'b0;
      end else begin
         cmd_q <= cmd_rdy;
         id_q <= ID_vld;
         if (clr_cmd_rdy && cmd[7:6] == 2'b01) begin
            state <= TRANSIT;
            in_transit <= 1'b1;
            dest_id <= cmd[5:0];
         end else if ((clr_cmd_rdy && cmd[7:6] == 2'b00) || (!clr_cmd_rdy && state == TRANSIT && id_match)) begin
            state <= IDLE;
            in_transit <= 1'b0;
         end
      end
`ifdef OBSTACLE_BUZZ_EN
   localparam int CW = $clog2(BUZZ_HALF);
   logic [CW-1:0] buzz_cnt;
   logic wrap;
   assign wrap = buzz_cnt == CW'(BUZZ_HALF - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         buzz_cnt <= '0;
         buzz <= 1'b0;
      end else if (in_transit && !OK2Move) begin
         buzz_cnt <= wrap ? '0 : buzz_cnt + 1'b1;
         buzz <= wrap ? ~buzz : buzz;
      end else begin
         buzz_cnt <= '0;
         buzz <= 1'b0;
      end
`else
   assign buzz = 1'b0;
`endif
   assign buzz_n = ~buzz;
endmodule

// File: tb/tb_station_cmd_ctrl.sv
// tb_station_cmd_ctrl: directed scenarios plus a randomized run against a transaction-level model.
module tb_station_cmd_ctrl;
   localparam int BH = 6250;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [7:0] cmd = '0, ID = '0;
   logic cmd_rdy = 1'b0, ID_vld = 1'b0, OK2Move = 1'b0;
   logic clr_cmd_rdy, clr_ID_vld, in_transit, go, buzz, buzz_n;
   int n_chk = 0, n_fail = 0;

   station_cmd_ctrl dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
      .ID(ID), .ID_vld(ID_vld), .clr_ID_vld(clr_ID_vld), .OK2Move(OK2Move),
      .in_transit(in_transit), .go(go), .buzz(buzz), .buzz_n(buzz_n)
   );

   always #5 clk = ~clk;

   task automatic put(input logic cr, input logic [7:0] c, input logic iv, input logic [7:0] i, input logic ok);
      @(negedge clk);
      cmd_rdy = cr;
      cmd = c;
      ID_vld = iv;
      ID = i;
      OK2Move = ok;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_chk++;
      if ({in_transit, go, buzz, buzz_n, clr_cmd_rdy, clr_ID_vld} !== 6'b000100) begin
         n_fail++;
         $display("FAIL reset_values: got %b required 000100", {in_transit, go, buzz, buzz_n, clr_cmd_rdy, clr_ID_vld});
      end
      @(negedge clk) rst_n = 1'b1;
      put(1, 8'h41, 0, 0, 1);
      step();
      put(0, 0, 0, 0, 1);
      n_chk++;
      if ({in_transit, go} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_setup: got %b required 11", {in_transit, go});
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({in_transit, go, buzz, buzz_n} !== 4'b0001) begin
         n_fail++;
         $display("FAIL async_reset: got %b required 0001", {in_transit, go, buzz, buzz_n});
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_go_stations();
      put(1, 8'h67, 0, 0, 1);
      n_chk++;
      if ({clr_cmd_rdy, clr_ID_vld} !== 2'b10) begin
         n_fail++;
         $display("FAIL go_clr: got %b required 10", {clr_cmd_rdy, clr_ID_vld});
      end
      step();
      n_chk++;
      if ({in_transit, go} !== 2'b11) begin
         n_fail++;
         $display("FAIL go_transit: got %b required 11", {in_transit, go});
      end
      put(0, 0, 1, 8'h14, 1);
      n_chk++;
      if (clr_ID_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL id14_clr: got %b required 1", clr_ID_vld);
      end
      step();
      n_chk++;
      if (in_transit !== 1'b1) begin
         n_fail++;
         $display("FAIL id14_stay: got %b required 1", in_transit);
      end
      put(0, 0, 0, 0, 1);
      put(0, 0, 1, 8'h27, 1);
      n_chk++;
      if (clr_ID_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL id27_clr: got %b required 1", clr_ID_vld);
      end
      step();
      n_chk++;
      if ({in_transit, go} !== 2'b00) begin
         n_fail++;
         $display("FAIL id27_stop: got %b required 00", {in_transit, go});
      end
      put(0, 0, 0, 0, 1);
   endtask

   task automatic test_invalid_id();
      put(1, 8'h66, 0, 0, 1);
      put(0, 0, 0, 0, 1);
      put(0, 0, 1, 8'h66, 1);
      n_chk++;
      if (clr_ID_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL invalid_clr: got %b required 1", clr_ID_vld);
      end
      step();
      n_chk++;
      if (in_transit !== 1'b1) begin
         n_fail++;
         $display("FAIL invalid_nostop: got %b required 1", in_transit);
      end
      put(0, 0, 0, 0, 1);
      put(0, 0, 1, 8'h26, 1);
      step();
      n_chk++;
      if (in_transit !== 1'b0) begin
         n_fail++;
         $display("FAIL valid_stop: got %b required 0", in_transit);
      end
      put(0, 0, 0, 0, 1);
   endtask

   task automatic test_priority();
      put(1, 8'h45, 0, 0, 1);
      put(0, 0, 0, 0, 1);
      put(1, 8'h00, 1, 8'h09, 1);
      n_chk++;
      if ({clr_cmd_rdy, clr_ID_vld} !== 2'b11) begin
         n_fail++;
         $display("FAIL stop_both_clr: got %b required 11", {clr_cmd_rdy, clr_ID_vld});
      end
      step();
      n_chk++;
      if (in_transit !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_wins: got %b required 0", in_transit);
      end
      put(0, 0, 0, 0, 1);
      put(1, 8'h45, 0, 0, 1);
      put(0, 0, 0, 0, 1);
      put(1, 8'h54, 1, 8'h05, 1);
      n_chk++;
      if ({clr_cmd_rdy, clr_ID_vld} !== 2'b11) begin
         n_fail++;
         $display("FAIL reload_both_clr: got %b required 11", {clr_cmd_rdy, clr_ID_vld});
      end
      step();
      n_chk++;
      if (in_transit !== 1'b1) begin
         n_fail++;
         $display("FAIL reload_wins: got %b required 1", in_transit);
      end
      put(0, 0, 0, 0, 1);
      put(1, 8'hA5, 1, 8'h14, 1);
      step();
      n_chk++;
      if (in_transit !== 1'b1) begin
         n_fail++;
         $display("FAIL ignored_op_discards_match: got %b required 1", in_transit);
      end
      put(0, 0, 0, 0, 1);
      put(0, 0, 1, 8'h05, 1);
      step();
      n_chk++;
      if (in_transit !== 1'b1) begin
         n_fail++;
         $display("FAIL old_dest_nomatch: got %b required 1", in_transit);
      end
      put(0, 0, 0, 0, 1);
      put(0, 0, 1, 8'h14, 1);
      step();
      n_chk++;
      if (in_transit !== 1'b0) begin
         n_fail++;
         $display("FAIL new_dest_match: got %b required 0", in_transit);
      end
      put(1, 8'hC3, 0, 0, 1);
      step();
      n_chk++;
      if (in_transit !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ignored_op: got %b required 0", in_transit);
      end
      put(0, 0, 0, 0, 1);
   endtask

   task automatic test_obstacle();
      int n;
      logic e;
`ifdef OBSTACLE_BUZZ_EN
      n = 3 * BH + 10;
`else
      n = 200;
`endif
      put(1, 8'h41, 0, 0, 1);
      step();
      put(0, 0, 0, 0, 0);
      n_chk++;
      if ({in_transit, go} !== 2'b10) begin
         n_fail++;
         $display("FAIL obst_go_low: got %b required 10", {in_transit, go});
      end
      for (int k = 1; k <= n; k++) begin
         step();
`ifdef OBSTACLE_BUZZ_EN
         e = ((k / BH) % 2) == 1;
`else
         e = 1'b0;
`endif
         n_chk++;
         if ({buzz, buzz_n} !== {e, ~e}) begin
            n_fail++;
            $display("FAIL buzz_cycle%0d: got %b required %b", k, {buzz, buzz_n}, {e, ~e});
         end
      end
      put(0, 0, 0, 0, 1);
      n_chk++;
      if (go !== 1'b1) begin
         n_fail++;
         $display("FAIL obst_clear_go: got %b required 1", go);
      end
      step();
      n_chk++;
      if ({buzz, buzz_n} !== 2'b01) begin
         n_fail++;
         $display("FAIL obst_clear_buzz: got %b required 01", {buzz, buzz_n});
      end
      put(1, 8'h00, 0, 0, 1);
      put(0, 0, 0, 0, 1);
   endtask

   task automatic test_handshake();
      int p;
      p = 0;
      for (int k = 0; k < 4; k++) begin
         put(1, 8'h80, 0, 0, 1);
         p += int'(clr_cmd_rdy);
      end
      put(0, 0, 0, 0, 1);
      n_chk++;
      if (p != 1 || in_transit !== 1'b0) begin
         n_fail++;
         $display("FAIL held_ignored_cmd: got %0d pulses transit %b required 1 pulse transit 0", p, in_transit);
      end
      p = 0;
      for (int k = 0; k < 4; k++) begin
         put(1, 8'h7F, 0, 0, 1);
         p += int'(clr_cmd_rdy);
      end
      put(0, 0, 0, 0, 1);
      n_chk++;
      if (p != 1 || in_transit !== 1'b1) begin
         n_fail++;
         $display("FAIL held_go_cmd: got %0d pulses transit %b required 1 pulse transit 1", p, in_transit);
      end
      p = 0;
      for (int k = 0; k < 3; k++) begin
         put(0, 0, 1, 8'h3F, 1);
         p += int'(clr_ID_vld);
      end
      put(0, 0, 0, 0, 1);
      n_chk++;
      if (p != 1 || in_transit !== 1'b0) begin
         n_fail++;
         $display("FAIL held_match_id: got %0d pulses transit %b required 1 pulse transit 0", p, in_transit);
      end
      p = 0;
      for (int k = 0; k < 3; k++) begin
         put(0, 0, 1, 8'h3F, 1);
         p += int'(clr_ID_vld);
      end
      put(0, 0, 0, 0, 1);
      n_chk++;
      if (p != 1 || in_transit !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_id_ignored: got %0d pulses transit %b required 1 pulse transit 0", p, in_transit);
      end
   endtask

   task automatic test_random();
      logic m_tr, c_cons, i_cons, e_c, e_i;
      logic [5:0] m_dest;
      int r;
      @(negedge clk) rst_n = 1'b0;
      #1 rst_n = 1'b1;
      m_tr = 1'b0;
      m_dest = '0;
      c_cons = 1'b1;
      i_cons = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (cmd_rdy && c_cons && $urandom_range(1) == 1) cmd_rdy = 1'b0;
         else if (!cmd_rdy && $urandom_range(2) == 0) begin
            cmd_rdy = 1'b1;
            cmd = {2'($urandom), 6'($urandom_range(7))};
            c_cons = 1'b0;
         end
         if (ID_vld && i_cons && $urandom_range(1) == 1) ID_vld = 1'b0;
         else if (!ID_vld && $urandom_range(1) == 0) begin
            r = int'($urandom_range(3));
            ID = r == 0 ? {2'b00, m_dest} : r == 1 ? {2'($urandom_range(3, 1)), m_dest} : {2'b00, 6'($urandom_range(7))};
            ID_vld = 1'b1;
            i_cons = 1'b0;
         end
         OK2Move = $urandom_range(3) != 0;
         #1;
         e_c = cmd_rdy && !c_cons;
         e_i = ID_vld && !i_cons;
         n_chk++;
         if ({clr_cmd_rdy, clr_ID_vld, go} !== {e_c, e_i, m_tr & OK2Move}) begin
            n_fail++;
            $display("FAIL rand_comb%0d: got %b required %b", k, {clr_cmd_rdy, clr_ID_vld, go}, {e_c, e_i, m_tr & OK2Move});
         end
         if (e_c) begin
            c_cons = 1'b1;
            if (cmd[7:6] == 2'b01) begin
               m_tr = 1'b1;
               m_dest = cmd[5:0];
            end else if (cmd[7:6] == 2'b00) m_tr = 1'b0;
         end else if (e_i && m_tr && ID == {2'b00, m_dest}) m_tr = 1'b0;
         if (e_i) i_cons = 1'b1;
         step();
         n_chk++;
         if (in_transit !== m_tr) begin
            n_fail++;
            $display("FAIL rand_transit%0d: got %b required %b", k, in_transit, m_tr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_go_stations();
      test_invalid_id();
      test_priority();
      test_obstacle();
      test_handshake();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
